move_input_controller: RTL and testbench

- Front-end stage that turns raw player buttons into validated moves for the tic-tac-toe game-logic stage.
- Debounces three buttons and keeps a wrapping cursor over cells 0..8.
- Checks the selected cell against the current board, then issues a one-cycle move strobe with position and player code.
- Alternates X/O only after the game-logic stage confirms the write on the board bus.

---
 rtl/move_input_controller.sv | 163 ++++++++++++++++
 tb/tb_move_input_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_input_controller.sv
// Button front-end for the tic-tac-toe game: debounces the raw buttons, moves a wrapping cursor,
// validates the selected cell and hands one move at a time to the game-logic stage.
module move_input_controller #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         WAIT_TIMEOUT    = 8,
    parameter logic [1:0] START_PLAYER    = 2'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_confirm,
    input  logic [17:0] board,
    input  logic        game_over,
    output logic [3:0]  cursor,
    output logic [3:0]  pos,
    output logic [1:0]  player,
    output logic        move_valid,
    output logic        reject,
    output logic [1:0]  state_dbg
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);
    localparam logic [TW-1:0] TO_LAST = TW'(WAIT_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COMMIT      = 2'd1,
        WAIT_UPDATE = 2'd2,
        ENDED       = 2'd3
    } state_t;

    // Button index: 0 = left, 1 = right, 2 = confirm
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_deb;
    logic [2:0]    r_press;
    logic [DW-1:0] r_dbCnt [3];

    state_t        r_state;
    logic [3:0]    r_cursor;
    logic [3:0]    r_pos;
    logic [1:0]    r_player;
    logic          r_moveValid;
    logic          r_reject;
    logic [TW-1:0] r_waitCnt;

    logic [1:0]    w_cell [16];
    logic [3:0]    w_cursorNext;
    logic          w_cursorFree;
    logic          w_posMatch;

    assign w_raw = {btn_confirm, btn_right, btn_left};

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_press <= '0;
            for (int i = 0; i < 3; i++) r_dbCnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_dbCnt[i] == DB_LAST) begin
                        r_deb[i]   <= r_sync2[i];
                        r_press[i] <= r_sync2[i];
                        r_dbCnt[i] <= '0;
                    end else begin
                        r_dbCnt[i] <= r_dbCnt[i] + DB_ONE;
                    end
                end else begin
                    r_dbCnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 16; k++) w_cell[k] = 2'b00;
        for (int k = 0; k < 9; k++) w_cell[k] = board[2*k +: 2];
    end

    assign w_cursorFree = (w_cell[r_cursor] == 2'b00);
    assign w_posMatch   = (w_cell[r_pos] == r_player);

    always_comb begin
        w_cursorNext = r_cursor;
        if (r_press[0] && !r_press[1]) begin
            w_cursorNext = (r_cursor == 4'd0) ? 4'd8 : r_cursor - 4'd1;
        end else if (r_press[1] && !r_press[0]) begin
            w_cursorNext = (r_cursor == 4'd8) ? 4'd0 : r_cursor + 4'd1;
        end
    end

    // move_valid is raised on leaving COMMIT, so a game_over seen in COMMIT cancels it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cursor    <= 4'd0;
            r_pos       <= 4'd0;
            r_player    <= START_PLAYER;
            r_moveValid <= 1'b0;
            r_reject    <= 1'b0;
            r_waitCnt   <= '0;
        end else begin
            r_moveValid <= 1'b0;
            r_reject    <= 1'b0;
            if (game_over) begin
                r_state <= ENDED;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cursor <= w_cursorNext;
                        if (r_press[2]) begin
                            if (w_cursorFree) begin
                                r_pos   <= r_cursor;
                                r_state <= COMMIT;
                            end else begin
                                r_reject <= 1'b1;
                            end
                        end
                    end
                    COMMIT: begin
                        r_moveValid <= 1'b1;
                        r_waitCnt   <= '0;
                        r_state     <= WAIT_UPDATE;
                    end
                    WAIT_UPDATE: begin
                        if (w_posMatch) begin
                            r_player <= (r_player == 2'd1) ? 2'd2 : 2'd1;
                            r_state  <= IDLE;
                        end else if (r_waitCnt == TO_LAST) begin
                            r_reject <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_waitCnt <= r_waitCnt + TO_ONE;
                        end
                    end
                    ENDED:   r_state <= ENDED;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign cursor     = r_cursor;
    assign pos        = r_pos;
    assign player     = r_player;
    assign move_valid = r_moveValid;
    assign reject     = r_reject;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_move_input_controller.sv
// Directed bench for move_input_controller: cursor table plus hand-timed move, reject, timeout,
// game-over and reset sequences against a small board-writing model.
module tb_move_input_controller;

    localparam int DB = 4;
    localparam int WT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_left, btn_right, btn_confirm;
    logic [17:0] board;
    logic        game_over;
    logic [3:0]  cursor, pos;
    logic [1:0]  player;
    logic        move_valid, reject;
    logic [1:0]  state_dbg;

    logic        boardLoad;
    logic [17:0] boardLoadVal;
    logic        modelEnable;

    int nCompared   = 0;
    int nMismatched = 0;
    int mvCount     = 0;
    int rjCount     = 0;

    move_input_controller #(
        .DEBOUNCE_CYCLES(DB),
        .WAIT_TIMEOUT   (WT),
        .START_PLAYER   (2'd1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_confirm(btn_confirm),
        .board      (board),
        .game_over  (game_over),
        .cursor     (cursor),
        .pos        (pos),
        .player     (player),
        .move_valid (move_valid),
        .reject     (reject),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Game-logic stand-in: writes the mover's code one cycle after move_valid
    always @(posedge clk) begin
        if (boardLoad) board <= boardLoadVal;
        else if (modelEnable && move_valid) board[2*int'(pos) +: 2] <= player;
    end

    always @(negedge clk) begin
        if (move_valid) mvCount++;
        if (reject) rjCount++;
    end

    typedef struct {
        logic       l;
        logic       r;
        logic [3:0] expCursor;
    } cursorVec_t;

    cursorVec_t vecs[8];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic c);
        btn_left = l; btn_right = r; btn_confirm = c;
        tick(DB + 4);
        btn_left = 0; btn_right = 0; btn_confirm = 0;
        tick(DB + 4);
    endtask

    task automatic loadBoard(input logic [17:0] v);
        boardLoadVal = v;
        boardLoad = 1'b1;
        tick(1);
        boardLoad = 1'b0;
    endtask

    // Holds confirm high and records when each strobe first appears, counting from the raw edge
    task automatic runConfirm(input int cycles, output int mvAt, output int mvN, output int rjAt,
                              output int rjN, output int posAt, output int playerAt);
        mvAt = -1; mvN = 0; rjAt = -1; rjN = 0; posAt = -1; playerAt = -1;
        btn_confirm = 1'b1;
        for (int k = 1; k <= cycles; k++) begin
            tick(1);
            if (move_valid) begin
                if (mvAt < 0) begin
                    mvAt = k; posAt = int'(pos); playerAt = int'(player);
                end
                mvN++;
            end
            if (reject) begin
                if (rjAt < 0) rjAt = k;
                rjN++;
            end
        end
    endtask

    task automatic releaseConfirm();
        btn_confirm = 1'b0;
        tick(DB + 4);
    endtask

    initial begin
        int mvAt, mvN, rjAt, rjN, posAt, playerAt, mvBefore, rjBefore;

        vecs[0] = '{l: 1'b1, r: 1'b0, expCursor: 4'd0};
        vecs[1] = '{l: 1'b1, r: 1'b0, expCursor: 4'd8};
        vecs[2] = '{l: 1'b0, r: 1'b1, expCursor: 4'd0};
        vecs[3] = '{l: 1'b1, r: 1'b0, expCursor: 4'd8};
        vecs[4] = '{l: 1'b1, r: 1'b0, expCursor: 4'd7};
        vecs[5] = '{l: 1'b0, r: 1'b1, expCursor: 4'd8};
        vecs[6] = '{l: 1'b1, r: 1'b1, expCursor: 4'd8};
        vecs[7] = '{l: 1'b0, r: 1'b1, expCursor: 4'd0};

        reset = 1'b1; btn_left = 0; btn_right = 0; btn_confirm = 0; game_over = 0;
        modelEnable = 1'b0; boardLoad = 1'b1; boardLoadVal = '0;
        tick(2);
        boardLoad = 1'b0;
        checkOutput("reset cursor", int'(cursor), 0);
        checkOutput("reset pos", int'(pos), 0);
        checkOutput("reset player", int'(player), 1);
        checkOutput("reset move_valid", int'(move_valid), 0);
        checkOutput("reset reject", int'(reject), 0);
        checkOutput("reset state", int'(state_dbg), 0);
        reset = 1'b0;
        tick(2);

        // Bouncing right press: cursor should step exactly once, 7 edges after the final rise
        btn_right = 1; tick(1); btn_right = 0; tick(1); btn_right = 1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checkOutput($sformatf("debounce cursor k=%0d", k), int'(cursor), (k >= 7) ? 1 : 0);
        end
        btn_right = 0;
        tick(DB + 4);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].l, vecs[i].r, 1'b0);
            checkOutput($sformatf("vec%0d cursor", i), int'(cursor), int'(vecs[i].expCursor));
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("cursor at 4", int'(cursor), 4);

        // Legal move on empty cell 4 with the board model answering
        modelEnable = 1'b1;
        runConfirm(10, mvAt, mvN, rjAt, rjN, posAt, playerAt);
        checkOutput("move latency", mvAt, 8);
        checkOutput("move strobe width", mvN, 1);
        checkOutput("move pos", posAt, 4);
        checkOutput("move player", playerAt, 1);
        checkOutput("move no reject", rjN, 0);
        checkOutput("player toggled", int'(player), 2);
        checkOutput("state after move", int'(state_dbg), 0);
        releaseConfirm();
        modelEnable = 1'b0;

        // Occupied cell is refused
        loadBoard(18'h00200);
        runConfirm(10, mvAt, mvN, rjAt, rjN, posAt, playerAt);
        checkOutput("occupied reject latency", rjAt, 7);
        checkOutput("occupied reject width", rjN, 1);
        checkOutput("occupied no move", mvN, 0);
        checkOutput("occupied player", int'(player), 2);
        releaseConfirm();

        // Board never written: reject WT cycles after WAIT_UPDATE is entered (cycle 8)
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("cursor at 5", int'(cursor), 5);
        runConfirm(8 + WT, mvAt, mvN, rjAt, rjN, posAt, playerAt);
        checkOutput("timeout move latency", mvAt, 8);
        checkOutput("timeout move pos", posAt, 5);
        checkOutput("timeout move player", playerAt, 2);
        checkOutput("timeout reject latency", rjAt, 8 + WT);
        checkOutput("timeout reject width", rjN, 1);
        checkOutput("timeout player", int'(player), 2);
        checkOutput("timeout state", int'(state_dbg), 0);
        releaseConfirm();

        // game_over arriving while in COMMIT cancels the strobe and locks the block
        mvBefore = mvCount; rjBefore = rjCount;
        btn_confirm = 1'b1;
        tick(7);
        checkOutput("in commit", int'(state_dbg), 1);
        game_over = 1'b1;
        tick(1);
        checkOutput("ended state", int'(state_dbg), 3);
        checkOutput("ended move_valid", int'(move_valid), 0);
        tick(3);
        game_over = 1'b0;
        btn_confirm = 1'b0;
        tick(DB + 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ended cursor frozen", int'(cursor), 5);
        checkOutput("ended state held", int'(state_dbg), 3);
        checkOutput("ended no move", mvCount - mvBefore, 0);
        checkOutput("ended no reject", rjCount - rjBefore, 0);

        // Reset in the middle of WAIT_UPDATE
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        loadBoard('0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("cursor at 1", int'(cursor), 1);
        btn_confirm = 1'b1;
        tick(9);
        checkOutput("waiting before reset", int'(state_dbg), 2);
        checkOutput("pending pos", int'(pos), 1);
        #2 reset = 1'b1;
        btn_confirm = 1'b0;
        #1;
        checkOutput("midreset cursor", int'(cursor), 0);
        checkOutput("midreset pos", int'(pos), 0);
        checkOutput("midreset player", int'(player), 1);
        checkOutput("midreset move_valid", int'(move_valid), 0);
        checkOutput("midreset reject", int'(reject), 0);
        checkOutput("midreset state", int'(state_dbg), 0);
        tick(2);
        reset = 1'b0;
        mvBefore = mvCount; rjBefore = rjCount;
        tick(20);
        checkOutput("post reset no move", mvCount - mvBefore, 0);
        checkOutput("post reset no reject", rjCount - rjBefore, 0);
        checkOutput("post reset state", int'(state_dbg), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
